// File: rtl/approx_err_monitor.sv
// approx_err_monitor: accumulates error metrics between an approximate and an
// exact adder result over a window of WINDOW samples.
//
// Handshakes:
//   A sample transfers on a rising edge where in_valid and in_ready are both 1.
//   A result transfers on a rising edge where res_valid and res_ready are both 1.
//   in_ready and res_valid do not depend on in_valid or res_ready.
//   clear forces in_ready low while it is held.
//
// Pipeline:
//   S1 registers |appx-accr| and a nonzero flag.
//   S2 folds that sample into the saturating sums, the max and the counters.
//
// fsm_state exposes the controller state (0=ACC, 1=DRAIN, 2=HOLD) for debug.
module approx_err_monitor #(
  parameter int W      = 32,
  parameter int ACC_W  = 100,
  parameter int CNT_W  = 32,
  parameter int WINDOW = 1024
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     appx,
  input  logic [W-1:0]     accr,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] n_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] sum_ae,
  output logic [ACC_W-1:0] sum_se,
  output logic [W:0]       max_ae,
  output logic             sat,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {ACC = 2'd0, DRAIN = 2'd1, HOLD = 2'd2} state_t;

  // Sum width that can hold any accumulator plus one square without wrapping.
  localparam int SW = ((ACC_W > 2*W+2) ? ACC_W : 2*W+2) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [CNT_W-1:0] WIN     = CNT_W'(WINDOW);

  state_t           state;
  logic             rdy_q;
  logic [CNT_W-1:0] acc_cnt;
  logic             s1_valid;
  logic [W:0]       s1_ae;
  logic             s1_nz;

  logic             accept;
  logic [W:0]       diff;
  logic [W:0]       ae_in;
  logic [2*W+1:0]   se;
  logic [SW-1:0]    ae_sum;
  logic [SW-1:0]    se_sum;
  logic             ae_ovf;
  logic             se_ovf;

  assign in_ready  = rdy_q & ~clear;
  assign accept    = in_valid & in_ready;
  assign fsm_state = state;

  // S1 datapath: exact difference in W+1 bits, then its magnitude.
  always_comb begin
    diff  = {appx[W-1], appx} - {accr[W-1], accr};
    ae_in = diff;
    if (diff[W]) ae_in = ~diff + (W+1)'(1);
  end

  // S2 datapath: square and wide sums, so that overflow is detectable.
  always_comb begin
    se     = {{(W+1){1'b0}}, s1_ae} * {{(W+1){1'b0}}, s1_ae};
    ae_sum = SW'(sum_ae) + SW'(s1_ae);
    se_sum = SW'(sum_se) + SW'(se);
    ae_ovf = ae_sum > SW'(ACC_MAX);
    se_ovf = se_sum > SW'(ACC_MAX);
  end

  // Window controller, S1/S2 pipeline registers and result registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= ACC;
      rdy_q     <= 1'b0;
      res_valid <= 1'b0;
      acc_cnt   <= '0;
      s1_valid  <= 1'b0;
      s1_ae     <= '0;
      s1_nz     <= 1'b0;
      n_cnt     <= '0;
      err_cnt   <= '0;
      sum_ae    <= '0;
      sum_se    <= '0;
      max_ae    <= '0;
      sat       <= 1'b0;
    end else if (clear) begin
      state     <= ACC;
      rdy_q     <= 1'b1;
      res_valid <= 1'b0;
      acc_cnt   <= '0;
      s1_valid  <= 1'b0;
      n_cnt     <= '0;
      err_cnt   <= '0;
      sum_ae    <= '0;
      sum_se    <= '0;
      max_ae    <= '0;
      sat       <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_ae <= ae_in;
        s1_nz <= (diff != '0);
      end

      if (s1_valid) begin
        sum_ae  <= ae_ovf ? ACC_MAX : ae_sum[ACC_W-1:0];
        sum_se  <= se_ovf ? ACC_MAX : se_sum[ACC_W-1:0];
        if (ae_ovf || se_ovf) sat <= 1'b1;
        if (s1_ae > max_ae) max_ae <= s1_ae;
        err_cnt <= err_cnt + CNT_W'(s1_nz);
        n_cnt   <= n_cnt + CNT_W'(1);
      end

      case (state)
        ACC: begin
          rdy_q <= 1'b1;
          if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
            if ((acc_cnt + CNT_W'(1)) == WIN) begin
              state <= DRAIN;
              rdy_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          rdy_q <= 1'b0;
          if (!s1_valid) begin
            state     <= HOLD;
            res_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (res_ready) begin
            state     <= ACC;
            rdy_q     <= 1'b1;
            res_valid <= 1'b0;
            acc_cnt   <= '0;
            n_cnt     <= '0;
            err_cnt   <= '0;
            sum_ae    <= '0;
            sum_se    <= '0;
            max_ae    <= '0;
            sat       <= 1'b0;
          end
        end
        default: begin
          state <= ACC;
          rdy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_approx_err_monitor.sv
// Bench for approx_err_monitor. Three instances share the input stimulus:
// A (ACC_W=100, WINDOW=4), B (ACC_W=8, WINDOW=4), C (ACC_W=100, WINDOW=100).
// sel picks the instance whose outputs are observed and modelled.
module tb_approx_err_monitor;

  typedef struct packed {
    logic [31:0] n;
    logic [31:0] err;
    logic [99:0] sae;
    logic [99:0] sse;
    logic [32:0] mx;
    logic        sat;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        res_ready = 1'b0;
  logic [31:0] appx = '0;
  logic [31:0] accr = '0;

  logic        in_ready_a, res_valid_a, sat_a;
  logic [31:0] n_cnt_a, err_cnt_a;
  logic [99:0] sum_ae_a, sum_se_a;
  logic [32:0] max_ae_a;
  logic [1:0]  state_a;

  logic        in_ready_b, res_valid_b, sat_b;
  logic [31:0] n_cnt_b, err_cnt_b;
  logic [7:0]  sum_ae_b, sum_se_b;
  logic [32:0] max_ae_b;
  logic [1:0]  state_b;

  logic        in_ready_c, res_valid_c, sat_c;
  logic [31:0] n_cnt_c, err_cnt_c;
  logic [99:0] sum_ae_c, sum_se_c;
  logic [32:0] max_ae_c;
  logic [1:0]  state_c;

  int          sel = 0;
  int          cur_win;
  int          cur_acc_w;
  logic        cur_in_ready, cur_res_valid, cur_sat;
  logic [31:0] cur_n, cur_err;
  logic [99:0] cur_sae, cur_sse;
  logic [32:0] cur_max;
  logic [1:0]  cur_state;

  res_t        exp_q[$];
  int          vecs = 0;
  int          errs = 0;

  logic [139:0] m_sae, m_sse;
  logic [65:0]  m_max;
  int           m_n, m_err;

  approx_err_monitor #(.W(32), .ACC_W(100), .CNT_W(32), .WINDOW(4)) dut_a (
    .Clk(clk), .Rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_a),
    .appx(appx), .accr(accr), .res_valid(res_valid_a), .res_ready(res_ready),
    .n_cnt(n_cnt_a), .err_cnt(err_cnt_a), .sum_ae(sum_ae_a), .sum_se(sum_se_a),
    .max_ae(max_ae_a), .sat(sat_a), .fsm_state(state_a));

  approx_err_monitor #(.W(32), .ACC_W(8), .CNT_W(32), .WINDOW(4)) dut_b (
    .Clk(clk), .Rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_b),
    .appx(appx), .accr(accr), .res_valid(res_valid_b), .res_ready(res_ready),
    .n_cnt(n_cnt_b), .err_cnt(err_cnt_b), .sum_ae(sum_ae_b), .sum_se(sum_se_b),
    .max_ae(max_ae_b), .sat(sat_b), .fsm_state(state_b));

  approx_err_monitor #(.W(32), .ACC_W(100), .CNT_W(32), .WINDOW(100)) dut_c (
    .Clk(clk), .Rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_c),
    .appx(appx), .accr(accr), .res_valid(res_valid_c), .res_ready(res_ready),
    .n_cnt(n_cnt_c), .err_cnt(err_cnt_c), .sum_ae(sum_ae_c), .sum_se(sum_se_c),
    .max_ae(max_ae_c), .sat(sat_c), .fsm_state(state_c));

  // Clock
  always #5 clk = ~clk;

  // Observed-instance mux
  always_comb begin
    cur_win = 4; cur_acc_w = 100;
    cur_in_ready = in_ready_a; cur_res_valid = res_valid_a; cur_sat = sat_a;
    cur_n = n_cnt_a; cur_err = err_cnt_a; cur_sae = sum_ae_a; cur_sse = sum_se_a;
    cur_max = max_ae_a; cur_state = state_a;
    if (sel == 1) begin
      cur_acc_w = 8;
      cur_in_ready = in_ready_b; cur_res_valid = res_valid_b; cur_sat = sat_b;
      cur_n = n_cnt_b; cur_err = err_cnt_b; cur_sae = 100'(sum_ae_b); cur_sse = 100'(sum_se_b);
      cur_max = max_ae_b; cur_state = state_b;
    end else if (sel == 2) begin
      cur_win = 100;
      cur_in_ready = in_ready_c; cur_res_valid = res_valid_c; cur_sat = sat_c;
      cur_n = n_cnt_c; cur_err = err_cnt_c; cur_sae = sum_ae_c; cur_sse = sum_se_c;
      cur_max = max_ae_c; cur_state = state_c;
    end
  end

  // Reference model: exact wide sums, clamped only when the window closes.
  function automatic void model_reset();
    m_sae = '0; m_sse = '0; m_max = '0; m_n = 0; m_err = 0;
  endfunction

  function automatic void model_add(input logic [31:0] a, input logic [31:0] b);
    longint       d;
    logic [65:0]  ae;
    logic [139:0] maxv;
    res_t         r;
    d  = longint'($signed(a)) - longint'($signed(b));
    ae = (d < 0) ? 66'(-d) : 66'(d);
    m_sae = m_sae + 140'(ae);
    m_sse = m_sse + 140'(ae * ae);
    if (ae > m_max) m_max = ae;
    if (d != 0) m_err++;
    m_n++;
    if (m_n == cur_win) begin
      maxv  = (140'(1) << cur_acc_w) - 140'(1);
      r.n   = 32'(m_n);
      r.err = 32'(m_err);
      r.sae = (m_sae > maxv) ? maxv[99:0] : m_sae[99:0];
      r.sse = (m_sse > maxv) ? maxv[99:0] : m_sse[99:0];
      r.mx  = m_max[32:0];
      r.sat = (m_sae > maxv) || (m_sse > maxv);
      exp_q.push_back(r);
      model_reset();
    end
  endfunction

  // Driver: present a pair and return just after the edge that accepts it.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    bit done;
    done = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; appx = a; accr = b;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (cur_in_ready) begin
        @(posedge clk);
        model_add(a, b);
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vecs++;
    if (!done) begin
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
      errs++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
  endtask

  // Scoreboard: wait for a result, compare with the queue head, consume it.
  task automatic get_result(input string name);
    bit   got;
    res_t e;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (cur_res_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    vecs++;
    if (!got) begin
      $display("FAIL %s res_valid_timeout: got 0, required 1", name);
      errs++;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (exp_q.size() == 0) begin
      $display("FAIL %s unexpected_result: n_cnt=%0d with empty expected queue", name, cur_n);
      errs++;
    end else begin
      e = exp_q.pop_front();
      if (cur_n !== e.n) begin $display("FAIL %s n_cnt: got %0d, required %0d", name, cur_n, e.n); errs++; end
      vecs++;
      if (cur_err !== e.err) begin $display("FAIL %s err_cnt: got %0d, required %0d", name, cur_err, e.err); errs++; end
      vecs++;
      if (cur_sae !== e.sae) begin $display("FAIL %s sum_ae: got %0h, required %0h", name, cur_sae, e.sae); errs++; end
      vecs++;
      if (cur_sse !== e.sse) begin $display("FAIL %s sum_se: got %0h, required %0h", name, cur_sse, e.sse); errs++; end
      vecs++;
      if (cur_max !== e.mx) begin $display("FAIL %s max_ae: got %0h, required %0h", name, cur_max, e.mx); errs++; end
      vecs++;
      if (cur_sat !== e.sat) begin $display("FAIL %s sat: got %0b, required %0b", name, cur_sat, e.sat); errs++; end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      #1;
      vecs++;
      if (cur_res_valid !== 1'b0 || cur_n !== 32'd0 || cur_in_ready !== 1'b1) begin
        $display("FAIL %s release: res_valid=%0b n_cnt=%0d in_ready=%0b, required 0 0 1",
                 name, cur_res_valid, cur_n, cur_in_ready);
        errs++;
      end
    end
  endtask

  task automatic test_reset();
    sel = 0;
    @(negedge clk);
    #1;
    vecs++;
    if (cur_in_ready !== 1'b0 || cur_res_valid !== 1'b0 || cur_n !== 32'd0 || cur_sae !== 100'd0 ||
        cur_max !== 33'd0 || cur_sat !== 1'b0 || cur_state !== 2'd0) begin
      $display("FAIL reset_values: in_ready=%0b res_valid=%0b n=%0d sae=%0h max=%0h sat=%0b state=%0d, required all 0",
               cur_in_ready, cur_res_valid, cur_n, cur_sae, cur_max, cur_sat, cur_state);
      errs++;
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    vecs++;
    if (cur_in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: got %0b, required 1", cur_in_ready);
      errs++;
    end
    model_reset();
  endtask

  task automatic test_t1();
    sel = 0;
    do_clear();
    send(32'd10, 32'd10);
    send(32'd5, 32'd8);
    send(-32'sd3, 32'd2);
    send(32'd100, -32'sd100);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    vecs++;
    if (cur_res_valid !== 1'b0 || cur_state !== 2'd1 || cur_in_ready !== 1'b0) begin
      $display("FAIL t1_edge1: res_valid=%0b state=%0d in_ready=%0b, required 0 1 0",
               cur_res_valid, cur_state, cur_in_ready);
      errs++;
    end
    @(negedge clk);
    vecs++;
    if (cur_res_valid !== 1'b0 || cur_n !== 32'd4) begin
      $display("FAIL t1_edge2: res_valid=%0b n_cnt=%0d, required 0 4", cur_res_valid, cur_n);
      errs++;
    end
    @(negedge clk);
    vecs++;
    if (cur_res_valid !== 1'b1 || cur_n !== 32'd4 || cur_err !== 32'd3 || cur_sae !== 100'd208 ||
        cur_sse !== 100'd40034 || cur_max !== 33'd200 || cur_sat !== 1'b0) begin
      $display("FAIL t1_result: rv=%0b n=%0d err=%0d sae=%0d sse=%0d max=%0d sat=%0b, required 1 4 3 208 40034 200 0",
               cur_res_valid, cur_n, cur_err, cur_sae, cur_sse, cur_max, cur_sat);
      errs++;
    end
    get_result("t1");
  endtask

  task automatic test_extremes();
    sel = 0;
    do_clear();
    send(32'h7FFFFFFF, 32'h80000000);
    idle(2);
    vecs++;
    if (cur_max !== 33'h0FFFFFFFF || cur_sse !== 100'h0FFFFFFFE00000001 || cur_sae !== 100'h0FFFFFFFF) begin
      $display("FAIL t2_pos: max=%0h sse=%0h sae=%0h, required ffffffff fffffffe00000001 ffffffff",
               cur_max, cur_sse, cur_sae);
      errs++;
    end
    send(32'h80000000, 32'h7FFFFFFF);
    idle(2);
    vecs++;
    if (cur_max !== 33'h0FFFFFFFF || cur_sse !== 100'h1FFFFFFFC00000002 || cur_sae !== 100'h1FFFFFFFE) begin
      $display("FAIL t2_swap: max=%0h sse=%0h sae=%0h, required ffffffff 1fffffffc00000002 1fffffffe",
               cur_max, cur_sse, cur_sae);
      errs++;
    end
    send(32'd0, 32'd0);
    send(32'hFFFFFFFF, 32'h00000001);
    idle(1);
    get_result("t2");
  endtask

  task automatic test_saturation();
    sel = 1;
    do_clear();
    for (int i = 0; i < 4; i++) send(32'd200, 32'd0);
    idle(3);
    vecs++;
    if (cur_sae !== 100'd255 || cur_sse !== 100'd255 || cur_sat !== 1'b1 ||
        cur_max !== 33'd200 || cur_n !== 32'd4) begin
      $display("FAIL t3_sat: sae=%0d sse=%0d sat=%0b max=%0d n=%0d, required 255 255 1 200 4",
               cur_sae, cur_sse, cur_sat, cur_max, cur_n);
      errs++;
    end
    get_result("t3");
  endtask

  task automatic test_backpressure();
    res_t e;
    sel = 0;
    do_clear();
    for (int i = 0; i < 4; i++) send($urandom, $urandom);
    idle(3);
    e = exp_q[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; appx = $urandom; accr = $urandom;
      #1;
      vecs++;
      if (cur_in_ready !== 1'b0 || cur_res_valid !== 1'b1 || cur_n !== 32'd4 ||
          cur_sae !== e.sae || cur_max !== e.mx) begin
        $display("FAIL t4_hold: in_ready=%0b res_valid=%0b n=%0d sae=%0h max=%0h, required 0 1 4 %0h %0h",
                 cur_in_ready, cur_res_valid, cur_n, cur_sae, cur_max, e.sae, e.mx);
        errs++;
      end
    end
    idle(1);
    get_result("t4_first");
    for (int i = 0; i < 4; i++) send($urandom, $urandom);
    idle(1);
    get_result("t4_next");
  endtask

  task automatic test_clear();
    sel = 0;
    do_clear();
    send(32'd50, 32'd1);
    send(32'd7, 32'd9);
    @(negedge clk);
    in_valid = 1'b1; appx = 32'd1000; accr = 32'd0; clear = 1'b1;
    #1;
    vecs++;
    if (cur_in_ready !== 1'b0) begin
      $display("FAIL t5_ready_with_clear: got %0b, required 0", cur_in_ready);
      errs++;
    end
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    model_reset();
    idle(3);
    vecs++;
    if (cur_n !== 32'd0 || cur_sae !== 100'd0 || cur_err !== 32'd0 || cur_max !== 33'd0 ||
        cur_state !== 2'd0 || cur_res_valid !== 1'b0 || cur_in_ready !== 1'b1) begin
      $display("FAIL t5_clear_mid: n=%0d sae=%0h err=%0d max=%0h state=%0d rv=%0b rdy=%0b, required 0 0 0 0 0 0 1",
               cur_n, cur_sae, cur_err, cur_max, cur_state, cur_res_valid, cur_in_ready);
      errs++;
    end
    for (int i = 0; i < 4; i++) send(32'd3, 32'd1);
    idle(3);
    @(negedge clk);
    clear = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0; res_ready = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    idle(3);
    vecs++;
    if (cur_res_valid !== 1'b0 || cur_n !== 32'd0 || cur_sae !== 100'd0 || cur_state !== 2'd0) begin
      $display("FAIL t5_clear_hold: rv=%0b n=%0d sae=%0h state=%0d, required 0 0 0 0",
               cur_res_valid, cur_n, cur_sae, cur_state);
      errs++;
    end
    send(32'd20, 32'd0);
    send(32'd0, 32'd20);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    vecs++;
    if (cur_n !== 32'd0 || cur_sae !== 100'd0 || cur_in_ready !== 1'b0 || cur_max !== 33'd0) begin
      $display("FAIL t5_async_rst: n=%0d sae=%0h rdy=%0b max=%0h, required 0 0 0 0",
               cur_n, cur_sae, cur_in_ready, cur_max);
      errs++;
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle(2);
    vecs++;
    if (cur_in_ready !== 1'b1 || cur_res_valid !== 1'b0 || cur_n !== 32'd0) begin
      $display("FAIL t5_after_rst: rdy=%0b rv=%0b n=%0d, required 1 0 0", cur_in_ready, cur_res_valid, cur_n);
      errs++;
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    int mode;
    sel = 2;
    do_clear();
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 1) == 1) idle(1);
      mode = $urandom_range(0, 3);
      a = $urandom;
      if (mode == 0) b = a;
      else if (mode == 1) b = a + 32'($urandom_range(0, 6)) - 32'd3;
      else b = $urandom;
      send(a, b);
      if (exp_q.size() > 0) begin
        idle(1);
        get_result("t6");
      end
    end
    idle(1);
    vecs++;
    if (exp_q.size() != 0) begin
      $display("FAIL t6_leftover: %0d results never produced, required 0", exp_q.size());
      errs++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_t1();
    test_extremes();
    test_saturation();
    test_backpressure();
    test_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
